// File: rtl/ofdm_tx_framer.sv
// OFDM transmit framer: buffers one IFFT symbol, emits it with its cyclic prefix, then zero guard samples.
// Optional build macro OFDM_FRAMER_TLAST_CHECK_EN adds a sticky input tlast/count mismatch flag on o_err.
`timescale 1ns/1ps
module ofdm_tx_framer #(
    parameter int g_ADDR_W = 14
) (
    input  logic        axis_aclk,
    input  logic        axis_areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [3:0]  m_axis_tkeep,
    input  logic [13:0] i_nfft,
    input  logic [11:0] i_cp_len,
    input  logic [3:0]  i_symbols,
    input  logic [31:0] i_guard_cycles,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_CP    = 3'd2;
    localparam logic [2:0] ST_SYM   = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    logic [2:0]          state;
    logic [g_ADDR_W-1:0] nfft_q;
    logic [g_ADDR_W-1:0] cp_start_q;
    logic [g_ADDR_W-1:0] wr_addr;
    logic [g_ADDR_W-1:0] rd_addr;
    logic [3:0]          sym_q;
    logic [3:0]          sym_cnt;
    logic [31:0]         guard_q;
    logic [31:0]         guard_cnt;

    logic [g_ADDR_W-1:0] nfft_w;
    logic [g_ADDR_W-1:0] cp_w;
    logic [g_ADDR_W-1:0] cp_eff;

    // A CP longer than the symbol is clamped so the read start never wraps below zero.
    assign nfft_w = g_ADDR_W'(i_nfft);
    assign cp_w   = g_ADDR_W'(i_cp_len);
    assign cp_eff = (cp_w > nfft_w) ? nfft_w : cp_w;

    logic s_accept;
    assign s_axis_tready = (state == ST_FILL);
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    logic [1:0]  out_cnt;
    logic [31:0] out_data;
    logic        out_last;
    logic [31:0] skid_data;
    logic        skid_last;

    logic        rd_vld;
    logic        rd_last;
    logic        rd_zero;
    logic [31:0] ram_q;
    logic [31:0] st_data;

    logic       m_pop;
    logic [1:0] occ;
    logic       issue_ok;
    logic       issue;
    logic       rd_en;
    logic       issue_last;

    // A sample is issued only if it is guaranteed a slot in the output stage when it lands a cycle later.
    assign m_axis_tvalid = (out_cnt != 2'd0);
    assign m_pop         = m_axis_tvalid && m_axis_tready;
    assign occ           = out_cnt + {1'b0, rd_vld};
    assign issue_ok      = (occ != 2'd2) || m_pop;
    assign issue         = issue_ok && ((state == ST_CP) || (state == ST_SYM) || (state == ST_GUARD));
    assign rd_en         = issue && (state != ST_GUARD);

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        issue_last = 1'b0;
        case (state)
            ST_SYM:   issue_last = (rd_addr == nfft_q) && (sym_cnt == sym_q) && (guard_q == 32'd0);
            ST_GUARD: issue_last = (guard_cnt == 32'd1);
            default:  issue_last = 1'b0;
        endcase
    end

    logic [31:0] mem [0:(1 << g_ADDR_W) - 1];

    // NOTE: the symbol buffer has no reset so it maps onto block RAM; its contents after reset are don't-care.
    always_ff @(posedge axis_aclk) begin
        if (s_accept) begin
            mem[wr_addr] <= s_axis_tdata;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            rd_zero <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_last <= issue_last;
            rd_zero <= (state == ST_GUARD);
        end
    end

    assign st_data = rd_zero ? 32'd0 : ram_q;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state      <= ST_IDLE;
            nfft_q     <= '0;
            cp_start_q <= '0;
            sym_q      <= 4'd0;
            guard_q    <= 32'd0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            sym_cnt    <= 4'd0;
            guard_cnt  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    nfft_q     <= nfft_w;
                    cp_start_q <= nfft_w - cp_eff;
                    sym_q      <= i_symbols;
                    guard_q    <= i_guard_cycles;
                    wr_addr    <= '0;
                    sym_cnt    <= 4'd0;
                    if (s_axis_tvalid) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (s_accept) begin
                        if (wr_addr == nfft_q) begin
                            wr_addr <= '0;
                            rd_addr <= cp_start_q;
                            state   <= ST_CP;
                        end else begin
                            wr_addr <= wr_addr + g_ADDR_W'(1);
                        end
                    end
                end
                ST_CP: begin
                    if (issue) begin
                        if (rd_addr == nfft_q) begin
                            rd_addr <= '0;
                            state   <= ST_SYM;
                        end else begin
                            rd_addr <= rd_addr + g_ADDR_W'(1);
                        end
                    end
                end
                ST_SYM: begin
                    if (issue) begin
                        if (rd_addr == nfft_q) begin
                            rd_addr <= '0;
                            if (sym_cnt < sym_q) begin
                                sym_cnt <= sym_cnt + 4'd1;
                                state   <= ST_FILL;
                            end else if (guard_q != 32'd0) begin
                                guard_cnt <= guard_q;
                                state     <= ST_GUARD;
                            end else begin
                                sym_cnt <= 4'd0;
                                state   <= ST_IDLE;
                            end
                        end else begin
                            rd_addr <= rd_addr + g_ADDR_W'(1);
                        end
                    end
                end
                ST_GUARD: begin
                    if (issue) begin
                        guard_cnt <= guard_cnt - 32'd1;
                        if (guard_cnt == 32'd1) begin
                            sym_cnt <= 4'd0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry output stage: out_* drives the port, skid_* absorbs the sample already in flight on a stall.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            out_cnt   <= 2'd0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
            skid_data <= 32'd0;
            skid_last <= 1'b0;
        end else begin
            case (out_cnt)
                2'd0: begin
                    if (rd_vld) begin
                        out_data <= st_data;
                        out_last <= rd_last;
                        out_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rd_vld && m_pop) begin
                        out_data <= st_data;
                        out_last <= rd_last;
                    end else if (m_pop) begin
                        out_last <= 1'b0;
                        out_cnt  <= 2'd0;
                    end else if (rd_vld) begin
                        skid_data <= st_data;
                        skid_last <= rd_last;
                        out_cnt   <= 2'd2;
                    end
                end
                default: begin
                    if (m_pop) begin
                        out_data <= skid_data;
                        out_last <= skid_last;
                        if (rd_vld) begin
                            skid_data <= st_data;
                            skid_last <= rd_last;
                        end else begin
                            out_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign m_axis_tdata = out_data;
    assign m_axis_tlast = out_last;
    assign m_axis_tkeep = 4'hF;
    assign o_busy       = (state != ST_IDLE);

`ifdef OFDM_FRAMER_TLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            err_q <= 1'b0;
        end else if (s_accept && (s_axis_tlast != (wr_addr == nfft_q))) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// Self-checking bench for ofdm_tx_framer: directed frames, expected samples pushed to a scoreboard queue.
`timescale 1ns/1ps
module tb_ofdm_tx_framer;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    localparam int MAX_WAIT = 1000;

    logic        axis_aclk = 1'b0;
    logic        axis_areset = 1'b1;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic [13:0] i_nfft = 14'd7;
    logic [11:0] i_cp_len = 12'd3;
    logic [3:0]  i_symbols = 4'd3;
    logic [31:0] i_guard_cycles = 32'd10;
    logic        o_busy;
    logic        o_err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   first_vld_cyc = -1;
    int   rdy_mode = 0;
    bit   abort = 1'b0;
    int   acc_cyc [0:64];
    exp_t exp_q [$];

    ofdm_tx_framer #(.g_ADDR_W(14)) dut (
        .axis_aclk      (axis_aclk),
        .axis_areset    (axis_areset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tkeep   (m_axis_tkeep),
        .i_nfft         (i_nfft),
        .i_cp_len       (i_cp_len),
        .i_symbols      (i_symbols),
        .i_guard_cycles (i_guard_cycles),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    always #5 axis_aclk = ~axis_aclk;

    always @(posedge axis_aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: constant high, or toggling every cycle for backpressure.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_axis_tready = (rdy_mode == 1) ? ~m_axis_tready : 1'b1;
        end
    end

    // Output monitor: a transfer seen at this negedge completes on the next rising edge.
    logic        stall_pend = 1'b0;
    logic [32:0] stall_val;
    exp_t        e;
    always @(negedge axis_aclk) begin
        if (axis_areset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", m_axis_tvalid, 1);
                check("stall_data_held", {m_axis_tlast, m_axis_tdata}, stall_val);
            end
            if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                check("output_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("out[%0d]", n_out + 1), {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
                end
                n_out++;
                stall_pend = 1'b0;
            end else if (m_axis_tvalid) begin
                stall_pend = 1'b1;
                stall_val  = {m_axis_tlast, m_axis_tdata};
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic push_frame(input int cp, input int syms, input int guard);
        int cpe;
        cpe = (cp > 7) ? 7 : cp;
        for (int s = 0; s <= syms; s++) begin
            for (int k = 7 - cpe; k <= 7; k++) exp_q.push_back('{1'b0, 32'(s * 8 + k + 1)});
            for (int k = 0; k <= 7; k++)
                exp_q.push_back('{(s == syms) && (k == 7) && (guard == 0), 32'(s * 8 + k + 1)});
        end
        for (int g = 0; g < guard; g++) exp_q.push_back('{g == guard - 1, 32'd0});
    endtask

    // Drives samples 1..n; tlast normally on every 8th, moved to bad_at (and dropped from bad_at+1) if nonzero.
    task automatic drive_samples(input int n, input int gap, input int bad_at);
        bit acc;
        int waited;
        for (int i = 1; i <= n; i++) begin
            if (abort) break;
            s_axis_tvalid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge axis_aclk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(i);
            s_axis_tlast  = (i == bad_at) || ((i % 8 == 0) && !(bad_at != 0 && i == bad_at + 1));
            acc    = 1'b0;
            waited = 0;
            while (!acc && !abort && waited < MAX_WAIT) begin
                @(negedge axis_aclk);
                acc = s_axis_tready;
                @(posedge axis_aclk);
                #1;
                waited++;
            end
            if (abort) break;
            check($sformatf("input_accept[%0d]", i), acc, 1);
            if (!acc) break;
            acc_cyc[i] = cyc;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 5000) begin
            @(posedge axis_aclk);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (6) @(posedge axis_aclk);
        #1;
    endtask

    task automatic run_frame(input int cp, input int syms, input int guard, input int gap, input int bad_at);
        int n_exp;
        i_nfft         = 14'd7;
        i_cp_len       = 12'(cp);
        i_symbols      = 4'(syms);
        i_guard_cycles = 32'(guard);
        push_frame(cp, syms, guard);
        n_exp         = exp_q.size();
        n_out         = 0;
        first_vld_cyc = -1;
        drive_samples((syms + 1) * 8, gap, bad_at);
        wait_drain();
        check("output_count", n_out, n_exp);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tkeep", m_axis_tkeep, 4'hF);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        @(posedge axis_aclk);
        #1;
        axis_areset = 1'b0;
        repeat (2) @(posedge axis_aclk);
        #1;

        // Basic frame plus first-CP latency.
        run_frame(3, 3, 10, 0, 0);
        check("first_cp_latency", first_vld_cyc, acc_cyc[8] + 2);
        check("basic_idle_after", o_busy, 0);

        // Zero guard.
        run_frame(3, 3, 0, 0, 0);
        check("zero_guard_idle", o_busy, 0);

        // Backpressure.
        rdy_mode = 1;
        run_frame(3, 3, 10, 0, 0);
        rdy_mode = 0;
        repeat (2) @(posedge axis_aclk);
        #1;

        // CP clamp with sparse input.
        run_frame(9, 1, 2, 4, 0);

        // Reset mid-frame during the second symbol's SYM phase.
        i_cp_len       = 12'd3;
        i_symbols      = 4'd3;
        i_guard_cycles = 32'd10;
        push_frame(3, 3, 10);
        n_out = 0;
        fork
            drive_samples(32, 0, 0);
            begin
                int waited;
                waited = 0;
                while (n_out < 18 && waited < 3000) begin
                    @(posedge axis_aclk);
                    waited++;
                end
                check("reached_second_sym", n_out >= 18, 1);
                @(posedge axis_aclk);
                #1;
                abort       = 1'b1;
                axis_areset = 1'b1;
                exp_q.delete();
                @(posedge axis_aclk);
                #1;
                axis_areset = 1'b0;
                @(negedge axis_aclk);
                check("midrst_m_tvalid", m_axis_tvalid, 0);
                check("midrst_s_tready", s_axis_tready, 0);
                check("midrst_busy", o_busy, 0);
            end
        join
        abort = 1'b0;
        @(posedge axis_aclk);
        #1;
        run_frame(3, 3, 10, 0, 0);

        // Early tlast on sample 7.
        run_frame(3, 3, 10, 0, 7);
`ifdef OFDM_FRAMER_TLAST_CHECK_EN
        check("tlast_err_sticky", o_err, 1);
`else
        check("tlast_err_tied_low", o_err, 0);
`endif
        @(posedge axis_aclk);
        #1;
        axis_areset = 1'b1;
        @(posedge axis_aclk);
        #1;
        axis_areset = 1'b0;
        @(negedge axis_aclk);
        check("err_cleared_by_reset", o_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
